// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
package imem_pkg;

    localparam logic [31:0] ERR_INST = 32'h0000_0013;

    typedef struct packed {
        logic        err;
        logic [31:0] inst;
    } imem_rsp_t;

    function automatic logic [29:0] word_idx(input logic [31:0] addr);
        return addr[31:2];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with modulo-DEPTH pointers, used as the response buffer.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = store[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: sync-read word array, one read stage, response buffer.
// Optional IMEM_STALL_CNT_EN adds a saturating stall_cnt output.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int RSP_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_inst,
    output logic        rsp_err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
`ifdef IMEM_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(RSP_DEPTH+1);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [29:0]   req_idx;
    logic [29:0]   ld_idx;
    logic [AW-1:0] req_word;
    logic [AW-1:0] ld_word;
    logic          req_err;
    logic          req_fire;
    logic          ld_hit;
    logic          unused_ld_lsb;

    logic          s1_valid;
    logic          s1_err;
    logic [31:0]   rd_word;
    imem_rsp_t     s1_rsp;
    imem_rsp_t     buf_head;
    imem_rsp_t     out_rsp;
    logic          buf_empty;
    logic [CW-1:0] buf_count;
    logic [CW-1:0] occ;
    logic          buf_push;
    logic          buf_pop;

    assign req_idx       = word_idx(req_addr);
    assign ld_idx        = word_idx(ld_addr);
    assign req_word      = req_idx[AW-1:0];
    assign ld_word       = ld_idx[AW-1:0];
    assign unused_ld_lsb = ^ld_addr[1:0];
    assign req_err       = (req_addr[1:0] != 2'b00) || (req_idx >= 30'(DEPTH_WORDS));
    assign ld_hit        = ld_en && (ld_idx < 30'(DEPTH_WORDS));

    assign occ       = CW'(s1_valid) + buf_count;
    assign req_ready = !rst && (occ < CW'(RSP_DEPTH));
    assign req_fire  = req_valid && req_ready;

    // Non-blocking read and write on the same edge give read-first collisions.
    always_ff @(posedge clk) begin
        if (ld_hit) begin
            mem[ld_word] <= ld_data;
        end
        if (req_fire && !req_err) begin
            rd_word <= mem[req_word];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= req_fire;
        end
        if (req_fire) begin
            s1_err <= req_err;
        end
    end

    always_comb begin
        s1_rsp.err  = s1_err;
        s1_rsp.inst = s1_err ? ERR_INST : rd_word;
    end

    // s1 never lingers: it is either taken directly by the fetcher or buffered.
    assign buf_push = s1_valid && !(buf_empty && rsp_ready);
    assign buf_pop  = rsp_ready && !buf_empty;

    sync_fifo #(
        .WIDTH ($bits(imem_rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data (s1_rsp),
        .pop       (buf_pop),
        .head      (buf_head),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    always_comb begin
        out_rsp   = buf_empty ? s1_rsp : buf_head;
        rsp_valid = !rst && (s1_valid || !buf_empty);
        rsp_err   = rsp_valid && out_rsp.err;
        rsp_inst  = rsp_valid ? out_rsp.inst : 32'h0;
    end

`ifdef IMEM_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (rsp_valid && !rsp_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Testbench for imem_responder: directed scenarios plus random traffic against a queue model.
module tb_imem_responder;
    localparam int DEPTH_WORDS = 256;
    localparam int RSP_DEPTH   = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_inst;
    logic        rsp_err;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
`ifdef IMEM_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int compared;
    int mismatched;

    // Reference model: word array plus a queue of outstanding responses {err, inst}.
    logic [31:0] mem_model [DEPTH_WORDS];
    logic [32:0] pend_q [$];
    logic [31:0] stall_model;

    imem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .RSP_DEPTH   (RSP_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_inst  (rsp_inst),
        .rsp_err   (rsp_err),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
`ifdef IMEM_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compare every DUT output with what the model predicts for the current cycle.
    task automatic checkState();
        logic exp_valid;
        logic exp_ready;
        exp_valid = !rst && (pend_q.size() > 0);
        exp_ready = !rst && (pend_q.size() < RSP_DEPTH);
        checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
            checkOutput("rsp_inst", rsp_inst, pend_q[0][31:0]);
            checkOutput("rsp_err", 32'(rsp_err), 32'(pend_q[0][32]));
        end
        if (rst) begin
            checkOutput("rst_inst", rsp_inst, 32'h0);
            checkOutput("rst_err", 32'(rsp_err), 32'h0);
        end
`ifdef IMEM_STALL_CNT_EN
        checkOutput("stall_cnt", stall_cnt, stall_model);
`endif
    endtask

    // Advance the model across the coming rising edge using the inputs just driven.
    task automatic modelEdge();
        logic        cur_valid;
        logic        cur_ready;
        logic [31:0] widx;
        logic        err;
        cur_valid = !rst && (pend_q.size() > 0);
        cur_ready = !rst && (pend_q.size() < RSP_DEPTH);
        if (rst) begin
            pend_q.delete();
            stall_model = 32'h0;
        end else begin
            if (cur_valid && !rsp_ready && stall_model != 32'hFFFF_FFFF) begin
                stall_model = stall_model + 1;
            end
            if (cur_valid && rsp_ready) begin
                void'(pend_q.pop_front());
            end
            if (req_valid && cur_ready) begin
                widx = req_addr >> 2;
                err  = (req_addr % 4 != 0) || (widx >= DEPTH_WORDS);
                pend_q.push_back(err ? {1'b1, 32'h0000_0013} : {1'b0, mem_model[widx]});
            end
        end
        widx = ld_addr >> 2;
        if (ld_en && widx < DEPTH_WORDS) begin
            mem_model[widx] = ld_data;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rv, input logic [31:0] ra,
                                 input logic rr, input logic le, input logic [31:0] la,
                                 input logic [31:0] ldd);
        rst       = r;
        req_valid = rv;
        req_addr  = ra;
        rsp_ready = rr;
        ld_en     = le;
        ld_addr   = la;
        ld_data   = ldd;
        modelEdge();
        @(negedge clk);
        checkState();
    endtask

    function automatic logic [31:0] randAddr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel == 0) return {22'($urandom_range(0, 511)), 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        if (sel == 1) return $urandom | 32'h0000_0400;
        return {22'h0, 8'($urandom_range(0, 255)), 2'b00};
    endfunction

    initial begin
        logic [31:0] old_word;
        compared    = 0;
        mismatched  = 0;
        stall_model = 32'h0;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_addr    = 32'h0;
        rsp_ready   = 1'b0;
        ld_en       = 1'b0;
        ld_addr     = 32'h0;
        ld_data     = 32'h0;
        @(negedge clk);

        for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_ready", 32'(req_ready), 32'h0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("release_ready", 32'(req_ready), 32'h1);

        for (int i = 0; i < DEPTH_WORDS; i++) begin
            applyStimulus(0, 0, 0, 1, 1, 32'(i * 4), (i < 4) ? 32'hA000_0000 + 32'(i) : $urandom);
        end

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 32'(i * 4), 1, 0, 0, 0);
            checkOutput("b2b_valid", 32'(rsp_valid), 32'h1);
            checkOutput("b2b_inst", rsp_inst, 32'hA000_0000 + 32'(i));
        end
        applyStimulus(0, 0, 0, 1, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 32'(i * 4), 0, 0, 0, 0);
            checkOutput("stall_head", rsp_inst, 32'hA000_0000);
        end
        checkOutput("stall_ready", 32'(req_ready), 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0, 0, 0);

        applyStimulus(0, 1, 32'h0000_0006, 1, 0, 0, 0);
        checkOutput("misalign_err", 32'(rsp_err), 32'h1);
        checkOutput("misalign_inst", rsp_inst, 32'h0000_0013);
        applyStimulus(0, 1, 32'h0000_0400, 1, 0, 0, 0);
        checkOutput("range_err", 32'(rsp_err), 32'h1);
        checkOutput("range_inst", rsp_inst, 32'h0000_0013);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);

        old_word = mem_model[4];
        applyStimulus(0, 1, 32'd16, 1, 1, 32'd16, 32'hDEAD_BEEF);
        checkOutput("collide_old", rsp_inst, old_word);
        applyStimulus(0, 1, 32'd16, 1, 0, 0, 0);
        checkOutput("collide_new", rsp_inst, 32'hDEAD_BEEF);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);

        applyStimulus(0, 1, 32'd0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'd4, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("midrst_valid", 32'(rsp_valid), 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("midrst_ready", 32'(req_ready), 32'h1);
        checkOutput("midrst_stale", 32'(rsp_valid), 32'h0);

`ifdef IMEM_STALL_CNT_EN
        applyStimulus(0, 1, 32'd0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("stall_five", stall_cnt, 32'd5);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("stall_clear", stall_cnt, 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
`endif

        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), randAddr(),
                          ($urandom_range(0, 9) < 7), ($urandom_range(0, 7) == 0),
                          {22'h0, 9'($urandom_range(0, 300)), 1'b0} << 1, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Responder end of the instruction-fetch interface. It serves fetch requests, carrying a byte address, from a fetch unit over a valid/ready request channel, and returns the instruction word over a valid/ready response channel. The block contains a synchronous-read word array, a one-stage read pipeline and a small response buffer, so the fetcher can stall without losing responses. A load port lets the boot/test harness write the array.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array (power of 2, 16..4096)
RSP_DEPTH, 2, response buffer entries and maximum requests in flight (2..8)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high (named rst; the _n suffix is reserved for active-low)
req_valid  in  1  fetch request valid
req_ready  out  1  responder can accept a request
req_addr  in  32  byte address of the instruction
rsp_valid  out  1  response valid
rsp_ready  in  1  fetcher accepts the response
rsp_inst  out  32  instruction word
rsp_err  out  1  request was misaligned or out of range
ld_en  in  1  load-port write enable
ld_addr  in  32  load-port byte address (bits [1:0] ignored)
ld_data  in  32  load-port write data

Behaviour:
- Handshakes: a request is accepted when req_valid && req_ready; a response is consumed when rsp_valid && rsp_ready. Once rsp_valid is asserted, it and the response payload are held until consumed.
- Read stage: an accepted request registers into s1 (valid, word index, err flag). The array is read synchronously that same edge.
- Occupancy: occ = s1_valid + buf_count. req_ready = !rst && (occ < RSP_DEPTH). req_ready is registered-state only and has no combinational path from rsp_ready or req_valid.
- Response output when the buffer is empty: s1 is presented directly (bypass). Minimum latency is therefore 1 cycle: a request accepted at edge N gives rsp_valid high after edge N.
- Response output otherwise: the buffer head is presented and s1 is pushed into the buffer.
- Ordering: responses are returned strictly in request order.
- Error: asserted when req_addr[1:0] != 0 or req_addr[31:2] >= DEPTH_WORDS. For an error, rsp_err=1 and rsp_inst=ERR_INST (32'h0000_0013, NOP); the array is not read.
- Full throughput: one request per cycle is sustained while rsp_ready=1.
- Buffer full (occ==RSP_DEPTH): req_ready=0. It reasserts the cycle after a pop reduces occ.
- Pointer wrap: buffer read and write pointers wrap modulo RSP_DEPTH. Push and pop in the same cycle leave buf_count unchanged.
- Load collision: ld_en writing the same word that an accepted request reads in the same cycle gives read-first behaviour (old data returned). A load write becomes visible to requests accepted on the next edge or later.
- Load range: ld_en with an out-of-range word index is ignored.
- Reset while asserted: s1_valid=0, buf_count=0, pointers=0, rsp_valid=0, rsp_err=0, rsp_inst=0, req_ready=0.
- Reset release: req_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation: all in-flight requests and buffered responses are dropped and no response is produced for them.
- Array contents are not affected by reset.

Optional Feature:
IMEM_STALL_CNT_EN:
- Defined: adds output port stall_cnt [31:0]. It increments on every cycle with rsp_valid && !rsp_ready, saturates at 32'hFFFF_FFFF and is cleared by rst.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package imem_pkg contains:
  - ERR_INST constant
  - imem_rsp_t packed struct {logic err; logic [31:0] inst;}
  - function word_idx(addr) returning addr[31:2]
- Sub-module sync_fifo (parameters WIDTH, DEPTH) for the response buffer, instantiated with WIDTH=$bits(imem_rsp_t) and DEPTH=RSP_DEPTH.

Test Plan:
- Load words 0..3 with 32'hA000_0000+i, keep rsp_ready=1, issue requests to addresses 0,4,8,12 back-to-back -> responses A000_0000..A000_0003 on 4 consecutive cycles, each 1 cycle after its request, rsp_err=0.
- Hold rsp_ready=0 and keep req_valid=1 -> exactly 2 requests accepted, req_ready=0, first response held stable. Release rsp_ready -> responses drain in order with no loss or duplication.
- Request address 32'h0000_0006, then 32'h0000_0400 (DEPTH_WORDS=256) -> both responses give rsp_err=1 with rsp_inst=32'h0000_0013.
- Same cycle: ld_en writes 32'hDEAD_BEEF to address 16 while a request to address 16 is accepted -> old value returned. A request to address 16 on the next cycle -> 32'hDEAD_BEEF.
- With 2 responses in flight and rsp_ready=0, pulse rst for 1 cycle -> rsp_valid=0 during and after reset, no stale responses appear, req_ready=1 one cycle after release.
- With IMEM_STALL_CNT_EN defined, hold rsp_ready=0 for 5 cycles while rsp_valid=1 -> stall_cnt=5. Assert rst -> stall_cnt=0.
